// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic edge feeder: FSM encodings, PE pipe depth, lane slicing.
package systolic_skew_feeder_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    // Done must trail the last operand by the PE multiplier depth.
    localparam int PE_PIPE_STAGES   = 2;
    localparam int DONE_LAG_DEFAULT = PE_PIPE_STAGES;

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// WIDTH x DEPTH shift register; exposes stages TAP_FIRST..DEPTH (1-based) as taps, lowest first.
// Latency: stage n holds the input from n edges ago; no backpressure, shifts every cycle.
module skew_delay_line #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 1,
    parameter int TAP_FIRST = DEPTH
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [WIDTH-1:0]                       d,
    output logic [(DEPTH-TAP_FIRST+1)*WIDTH-1:0]   taps
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < DEPTH; j++) begin
                stage[j] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int j = 1; j < DEPTH; j++) begin
                stage[j] <= stage[j-1];
            end
        end
    end

    for (genvar t = 0; t < DEPTH - TAP_FIRST + 1; t++) begin : g_tap
        assign taps[t*WIDTH +: WIDTH] = stage[TAP_FIRST-1+t];
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skews one operand vector per beat onto the array edge (lane i delayed i cycles) with per-lane done pulses.
// Latency 1+i cycles on lane i; s_ready drops from last beat until tile_ack is seen in HOLD.
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int LANES    = 4,
    parameter int DONE_LAG = DONE_LAG_DEFAULT,
    parameter int MAX_K    = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [LANES*WIDTH-1:0]      s_data,
    input  logic                        s_last,
    output logic [LANES*WIDTH-1:0]      lane_data,
    output logic [LANES-1:0]            lane_done,
    output logic                        busy,
    output logic                        tile_hold,
    input  logic                        tile_ack,
    output logic [$clog2(MAX_K+1)-1:0]  k_count,
    output logic                        err_overrun
);

    localparam int KW      = $clog2(MAX_K+1);
    localparam int FLUSH_W = $clog2(LANES+DONE_LAG+1);
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(LANES-1+DONE_LAG);
    localparam logic [KW-1:0]      K_LAST     = KW'(MAX_K-1);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [FLUSH_W-1:0] flush_cnt;
    logic               accept;
    logic               at_limit;
    logic               beat_last;
    logic               overrun;

    assign accept    = s_valid && s_ready;
    assign at_limit  = (k_count == K_LAST);
    assign beat_last = accept && (s_last || at_limit);
    assign overrun   = accept && !s_last && at_limit;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_STREAM: begin
                if (beat_last) begin
                    state_nxt = ST_FLUSH;
                end else if (accept) begin
                    state_nxt = ST_STREAM;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt == '0) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tile_ack) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            s_ready     <= 1'b1;
            busy        <= 1'b0;
            tile_hold   <= 1'b0;
            k_count     <= '0;
            err_overrun <= 1'b0;
            flush_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            s_ready   <= (state_nxt == ST_IDLE) || (state_nxt == ST_STREAM);
            busy      <= (state_nxt == ST_STREAM) || (state_nxt == ST_FLUSH);
            tile_hold <= (state_nxt == ST_HOLD);

            if (state == ST_HOLD && tile_ack) begin
                k_count <= '0;
            end else if (accept) begin
                k_count <= k_count + 1'b1;
            end

            if (overrun) begin
                err_overrun <= 1'b1;
            end

            if (state != ST_FLUSH && state_nxt == ST_FLUSH) begin
                flush_cnt <= FLUSH_LOAD;
            end else if (state == ST_FLUSH && flush_cnt != '0) begin
                flush_cnt <= flush_cnt - 1'b1;
            end
        end
    end

    // Non-accepted cycles feed zeros, which the MAC treats as no-ops.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] lane_in;
        assign lane_in = accept ? s_data[lane_lsb(i, WIDTH) +: WIDTH] : '0;

        skew_delay_line #(
            .WIDTH (WIDTH),
            .DEPTH (i+1)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .d     (lane_in),
            .taps  (lane_data[lane_lsb(i, WIDTH) +: WIDTH])
        );
    end

    skew_delay_line #(
        .WIDTH     (1),
        .DEPTH     (LANES+DONE_LAG),
        .TAP_FIRST (DONE_LAG+1)
    ) u_done (
        .clk   (clk),
        .reset (reset),
        .d     (beat_last),
        .taps  (lane_done)
    );

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: LANES=4, DONE_LAG=2, MAX_K=4, hand-computed expectations.
module tb_systolic_skew_feeder;

    localparam int WIDTH    = 16;
    localparam int LANES    = 4;
    localparam int DONE_LAG = 2;
    localparam int MAX_K    = 4;
    localparam int KW       = $clog2(MAX_K+1);
    localparam int VW       = LANES*WIDTH;

    logic            clk = 1'b0;
    logic            reset;
    logic            s_valid;
    logic            s_ready;
    logic [VW-1:0]   s_data;
    logic            s_last;
    logic [VW-1:0]   lane_data;
    logic [LANES-1:0] lane_done;
    logic            busy;
    logic            tile_hold;
    logic            tile_ack;
    logic [KW-1:0]   k_count;
    logic            err_overrun;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    systolic_skew_feeder #(
        .WIDTH    (WIDTH),
        .LANES    (LANES),
        .DONE_LAG (DONE_LAG),
        .MAX_K    (MAX_K)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .lane_data   (lane_data),
        .lane_done   (lane_done),
        .busy        (busy),
        .tile_hold   (tile_hold),
        .tile_ack    (tile_ack),
        .k_count     (k_count),
        .err_overrun (err_overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] vec(input logic [15:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [WIDTH-1:0] lane_of(input logic [VW-1:0] v, input int i);
        return v[i*WIDTH +: WIDTH];
    endfunction

    task automatic idle_inputs();
        s_valid  = 1'b0;
        s_last   = 1'b0;
        s_data   = '0;
        tile_ack = 1'b0;
    endtask

    task automatic finish_tile(input string name);
        int n = 0;
        idle_inputs();
        while (tile_hold !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (tile_hold !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_hold_wait: tile_hold=%b expected 1 within 20 cycles", name, tile_hold);
        end
        tile_ack = 1'b1;
        tick();
        tile_ack = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors += 7;
        if (lane_data !== '0) begin miscompares++; $display("FAIL rst_lane_data: got %h expected 0", lane_data); end
        if (lane_done !== '0) begin miscompares++; $display("FAIL rst_lane_done: got %b expected 0", lane_done); end
        if (s_ready !== 1'b1) begin miscompares++; $display("FAIL rst_s_ready: got %b expected 1", s_ready); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (tile_hold !== 1'b0) begin miscompares++; $display("FAIL rst_tile_hold: got %b expected 0", tile_hold); end
        if (k_count !== '0) begin miscompares++; $display("FAIL rst_k_count: got %0d expected 0", k_count); end
        if (err_overrun !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b expected 0", err_overrun); end
    endtask

    task automatic test_single_tile();
        logic [VW-1:0]    ld [10];
        logic [LANES-1:0] dn [10];
        logic             th [10];
        logic             sr [10];
        logic [LANES-1:0] exp_dn;
        for (int c = 0; c < 10; c++) begin
            idle_inputs();
            if (c < 3) begin
                s_valid = 1'b1;
                s_data  = vec(16'(4*c+1), 16'(4*c+2), 16'(4*c+3), 16'(4*c+4));
                s_last  = (c == 2);
            end
            tick();
            ld[c] = lane_data; dn[c] = lane_done; th[c] = tile_hold; sr[c] = s_ready;
        end
        for (int j = 0; j < 3; j++) begin
            vectors += 2;
            if (lane_of(ld[3+j], 3) !== 16'(4*(j+1))) begin
                miscompares++;
                $display("FAIL tile_lane3_e%0d: got %0d expected %0d", 3+j, lane_of(ld[3+j], 3), 4*(j+1));
            end
            if (lane_of(ld[j], 0) !== 16'(4*j+1)) begin
                miscompares++;
                $display("FAIL tile_lane0_e%0d: got %0d expected %0d", j, lane_of(ld[j], 0), 4*j+1);
            end
        end
        vectors++;
        if (lane_of(ld[3], 0) !== 16'd0) begin miscompares++; $display("FAIL tile_lane0_pad: got %0d expected 0", lane_of(ld[3], 0)); end
        for (int c = 3; c < 9; c++) begin
            exp_dn = (c >= 4 && c <= 7) ? LANES'(1 << (c-4)) : '0;
            vectors++;
            if (dn[c] !== exp_dn) begin
                miscompares++;
                $display("FAIL tile_done_e%0d: got %b expected %b", c, dn[c], exp_dn);
            end
        end
        vectors += 5;
        if (th[7] !== 1'b0) begin miscompares++; $display("FAIL tile_hold_e7: got %b expected 0", th[7]); end
        if (th[8] !== 1'b1) begin miscompares++; $display("FAIL tile_hold_e8: got %b expected 1", th[8]); end
        if (sr[1] !== 1'b1) begin miscompares++; $display("FAIL tile_ready_e1: got %b expected 1", sr[1]); end
        if (sr[2] !== 1'b0) begin miscompares++; $display("FAIL tile_ready_e2: got %b expected 0", sr[2]); end
        if (k_count !== KW'(3)) begin miscompares++; $display("FAIL tile_kcount: got %0d expected 3", k_count); end
        tile_ack = 1'b1;
        tick();
        tile_ack = 1'b0;
        vectors += 3;
        if (s_ready !== 1'b1) begin miscompares++; $display("FAIL tile_ack_ready: got %b expected 1", s_ready); end
        if (k_count !== '0) begin miscompares++; $display("FAIL tile_ack_kcount: got %0d expected 0", k_count); end
        if (tile_hold !== 1'b0) begin miscompares++; $display("FAIL tile_ack_hold: got %b expected 0", tile_hold); end
    endtask

    task automatic test_bubbles();
        logic [VW-1:0] ld [8];
        logic [KW-1:0] kc [8];
        for (int c = 0; c < 8; c++) begin
            idle_inputs();
            if (c == 0) begin s_valid = 1'b1; s_data = vec(16'd11, 16'd12, 16'd13, 16'd14); end
            if (c == 1) s_data = '1;
            if (c == 2) begin s_valid = 1'b1; s_data = vec(16'd21, 16'd22, 16'd23, 16'd24); s_last = 1'b1; end
            tick();
            ld[c] = lane_data; kc[c] = k_count;
        end
        for (int i = 0; i < LANES; i++) begin
            vectors += 3;
            if (lane_of(ld[i], i) !== 16'(11+i)) begin
                miscompares++; $display("FAIL bub_lane%0d_first: got %0d expected %0d", i, lane_of(ld[i], i), 11+i);
            end
            if (lane_of(ld[i+1], i) !== 16'd0) begin
                miscompares++; $display("FAIL bub_lane%0d_gap: got %0d expected 0", i, lane_of(ld[i+1], i));
            end
            if (lane_of(ld[i+2], i) !== 16'(21+i)) begin
                miscompares++; $display("FAIL bub_lane%0d_second: got %0d expected %0d", i, lane_of(ld[i+2], i), 21+i);
            end
        end
        vectors += 2;
        if (kc[1] !== KW'(1)) begin miscompares++; $display("FAIL bub_kcount_e1: got %0d expected 1", kc[1]); end
        if (kc[2] !== KW'(2)) begin miscompares++; $display("FAIL bub_kcount_e2: got %0d expected 2", kc[2]); end
        finish_tile("bub");
    endtask

    task automatic test_single_beat();
        logic             dn0 [8];
        logic             th  [8];
        logic             sr0;
        logic             bz0;
        logic [WIDTH-1:0] l0;
        for (int c = 0; c < 8; c++) begin
            idle_inputs();
            if (c == 0) begin s_valid = 1'b1; s_data = vec(16'd7, 16'd0, 16'd0, 16'd0); s_last = 1'b1; end
            tick();
            if (c == 0) begin sr0 = s_ready; bz0 = busy; l0 = lane_of(lane_data, 0); end
            dn0[c] = lane_done[0]; th[c] = tile_hold;
        end
        vectors += 3;
        if (sr0 !== 1'b0) begin miscompares++; $display("FAIL one_ready: got %b expected 0", sr0); end
        if (bz0 !== 1'b1) begin miscompares++; $display("FAIL one_busy: got %b expected 1", bz0); end
        if (l0 !== 16'd7) begin miscompares++; $display("FAIL one_lane0: got %0d expected 7", l0); end
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (dn0[c] !== (c == 2)) begin
                miscompares++; $display("FAIL one_done0_e%0d: got %b expected %b", c, dn0[c], (c == 2));
            end
        end
        vectors += 2;
        if (th[5] !== 1'b0) begin miscompares++; $display("FAIL one_hold_e5: got %b expected 0", th[5]); end
        if (th[6] !== 1'b1) begin miscompares++; $display("FAIL one_hold_e6: got %b expected 1", th[6]); end
        finish_tile("one");
    endtask

    task automatic test_hold_handshake();
        logic th [10];
        logic bz [10];
        for (int c = 0; c < 10; c++) begin
            idle_inputs();
            if (c == 0) begin s_valid = 1'b1; s_data = vec(16'd3, 16'd3, 16'd3, 16'd3); s_last = 1'b1; end
            if (c == 2) tile_ack = 1'b1;
            tick();
            th[c] = tile_hold; bz[c] = busy;
        end
        vectors += 4;
        if (th[2] !== 1'b0) begin miscompares++; $display("FAIL hs_flush_ack_hold: got %b expected 0", th[2]); end
        if (bz[3] !== 1'b1) begin miscompares++; $display("FAIL hs_flush_ack_busy: got %b expected 1", bz[3]); end
        if (th[6] !== 1'b1) begin miscompares++; $display("FAIL hs_hold_e6: got %b expected 1", th[6]); end
        if (th[9] !== 1'b1) begin miscompares++; $display("FAIL hs_hold_e9: got %b expected 1", th[9]); end
        tile_ack = 1'b1;
        tick();
        tile_ack = 1'b0;
        vectors += 3;
        if (s_ready !== 1'b1) begin miscompares++; $display("FAIL hs_ack_ready: got %b expected 1", s_ready); end
        if (k_count !== '0) begin miscompares++; $display("FAIL hs_ack_kcount: got %0d expected 0", k_count); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL hs_ack_busy: got %b expected 0", busy); end
        tile_ack = 1'b1;
        tick();
        tile_ack = 1'b0;
        vectors += 2;
        if (s_ready !== 1'b1) begin miscompares++; $display("FAIL hs_idle_ack_ready: got %b expected 1", s_ready); end
        if (tile_hold !== 1'b0) begin miscompares++; $display("FAIL hs_idle_ack_hold: got %b expected 0", tile_hold); end
    endtask

    task automatic test_overrun();
        logic [VW-1:0]    ld [11];
        logic [LANES-1:0] dn [11];
        logic [KW-1:0]    kc [11];
        logic             er [11];
        logic             sr [11];
        logic             th [11];
        logic [LANES-1:0] exp_dn;
        for (int c = 0; c < 11; c++) begin
            idle_inputs();
            s_valid = 1'b1;
            if (c < 4) s_data = vec(16'(16*(c+1)), 16'd1, 16'd1, 16'd1);
            else       s_data = vec(16'hBAD, 16'hBAD, 16'hBAD, 16'hBAD);
            tick();
            ld[c] = lane_data; dn[c] = lane_done; kc[c] = k_count;
            er[c] = err_overrun; sr[c] = s_ready; th[c] = tile_hold;
        end
        vectors += 6;
        if (kc[3] !== KW'(4)) begin miscompares++; $display("FAIL ovr_kcount_e3: got %0d expected 4", kc[3]); end
        if (kc[8] !== KW'(4)) begin miscompares++; $display("FAIL ovr_kcount_e8: got %0d expected 4", kc[8]); end
        if (er[2] !== 1'b0) begin miscompares++; $display("FAIL ovr_err_e2: got %b expected 0", er[2]); end
        if (er[3] !== 1'b1) begin miscompares++; $display("FAIL ovr_err_e3: got %b expected 1", er[3]); end
        if (sr[3] !== 1'b0) begin miscompares++; $display("FAIL ovr_ready_e3: got %b expected 0", sr[3]); end
        if (th[9] !== 1'b1) begin miscompares++; $display("FAIL ovr_hold_e9: got %b expected 1", th[9]); end
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (lane_of(ld[c], 0) !== ((c < 4) ? 16'(16*(c+1)) : 16'd0)) begin
                miscompares++;
                $display("FAIL ovr_lane0_e%0d: got %0d expected %0d", c, lane_of(ld[c], 0), (c < 4) ? 16*(c+1) : 0);
            end
        end
        for (int c = 4; c < 10; c++) begin
            exp_dn = (c >= 5 && c <= 8) ? LANES'(1 << (c-5)) : '0;
            vectors++;
            if (dn[c] !== exp_dn) begin
                miscompares++; $display("FAIL ovr_done_e%0d: got %b expected %b", c, dn[c], exp_dn);
            end
        end
        s_valid = 1'b0;
        tile_ack = 1'b1;
        tick();
        tile_ack = 1'b0;
        vectors += 2;
        if (err_overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_err_sticky: got %b expected 1", err_overrun); end
        if (k_count !== '0) begin miscompares++; $display("FAIL ovr_ack_kcount: got %0d expected 0", k_count); end
    endtask

    task automatic test_reset_mid_flush();
        idle_inputs();
        s_valid = 1'b1; s_data = vec(16'd5, 16'd6, 16'd7, 16'd8);
        tick();
        s_data = vec(16'd9, 16'd9, 16'd9, 16'd9); s_last = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL rmf_busy_pre: got %b expected 1", busy); end
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            vectors += 2;
            if (lane_data !== '0) begin miscompares++; $display("FAIL rmf_lane_data_c%0d: got %h expected 0", c, lane_data); end
            if (lane_done !== '0) begin miscompares++; $display("FAIL rmf_lane_done_c%0d: got %b expected 0", c, lane_done); end
            tick();
        end
        vectors += 5;
        if (s_ready !== 1'b1) begin miscompares++; $display("FAIL rmf_ready: got %b expected 1", s_ready); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rmf_busy: got %b expected 0", busy); end
        if (tile_hold !== 1'b0) begin miscompares++; $display("FAIL rmf_hold: got %b expected 0", tile_hold); end
        if (k_count !== '0) begin miscompares++; $display("FAIL rmf_kcount: got %0d expected 0", k_count); end
        if (err_overrun !== 1'b0) begin miscompares++; $display("FAIL rmf_err: got %b expected 0", err_overrun); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_tile();
        test_bubbles();
        test_single_beat();
        test_hold_handshake();
        test_overrun();
        test_reset_mid_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
